// File: rtl/carregador_programa.sv
// rtl/carregador_programa.sv - program loader and 16-word instruction memory for the 4-bit CPU
module carregador_programa #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic              wr_valid,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              wr_ready,
  input  logic              end_load,
  input  logic [ADDR_W-1:0] addr,
  output logic [WIDTH-1:0]  data_out,
  output logic              cpu_run,
  output logic [ADDR_W:0]   words_loaded,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } st_t;

  st_t               st;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   cnt;
  logic [WIDTH-1:0]  mem [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      st  <= IDLE;
      ptr <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (load_start) begin
      // a restart discards any word presented in the same cycle
      st  <= LOAD;
      ptr <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (st)
        IDLE: st <= IDLE;
        LOAD: begin
          if (wr_valid) begin
            mem[ptr] <= wr_data;
            ptr      <= ptr + 1'b1;
            cnt      <= cnt + 1'b1;
            if (cnt == (ADDR_W+1)'(DEPTH - 1)) st <= RUN;
          end
          if (end_load) st <= RUN;
        end
        RUN:     st <= RUN;
        default: st <= IDLE;
      endcase
    end
  end

  assign wr_ready     = (st == LOAD);
  assign cpu_run      = (st == RUN);
  assign data_out     = (st == RUN) ? mem[addr] : '0;
  assign words_loaded = cnt;
  assign state        = st;

endmodule

// File: tb/tb_carregador_programa.sv
// tb/tb_carregador_programa.sv - scoreboard bench for carregador_programa
module tb_carregador_programa;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load_start = 1'b0;
  logic       wr_valid = 1'b0;
  logic [3:0] wr_data = 4'd0;
  logic       wr_ready;
  logic       end_load = 1'b0;
  logic [3:0] addr = 4'd0;
  logic [3:0] data_out;
  logic       cpu_run;
  logic [4:0] words_loaded;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_mem [16];
  int         m_st  = 0;
  int         m_ptr = 0;
  int         m_cnt = 0;
  logic [3:0] exp_q [$];

  carregador_programa dut (
    .clock(clock), .reset(reset), .load_start(load_start),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .end_load(end_load), .addr(addr), .data_out(data_out),
    .cpu_run(cpu_run), .words_loaded(words_loaded), .state(state)
  );

  always #50 clock = ~clock;

  task automatic confere(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one clock edge with the given inputs; the reference model follows the same edge
  task automatic step(input logic rs, input logic ls, input logic wv,
                      input logic [3:0] wd, input logic el, input string tag);
    reset = rs; load_start = ls; wr_valid = wv; wr_data = wd; end_load = el;
    if (rs || ls) begin
      m_st  = rs ? 0 : 1;
      m_ptr = 0;
      m_cnt = 0;
      for (int i = 0; i < 16; i++) m_mem[i] = 4'd0;
    end else if (m_st == 1) begin
      if (wv) begin
        m_mem[m_ptr] = wd;
        m_ptr = (m_ptr + 1) % 16;
        m_cnt = m_cnt + 1;
        if (m_cnt == 16) m_st = 2;
      end
      if (el) m_st = 2;
    end
    @(posedge clock);
    #1;
    reset = 1'b0; load_start = 1'b0; wr_valid = 1'b0; end_load = 1'b0;
    confere({tag, "_state"}, 32'(state), 32'(m_st));
    confere({tag, "_words"}, 32'(words_loaded), 32'(m_cnt));
    confere({tag, "_wr_ready"}, 32'(wr_ready), 32'(m_st == 1));
    confere({tag, "_cpu_run"}, 32'(cpu_run), 32'(m_st == 2));
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 16; a++) exp_q.push_back((m_st == 2) ? m_mem[a] : 4'd0);
    for (int a = 0; a < 16; a++) begin
      logic [3:0] e;
      addr = 4'(a);
      #1;
      e = exp_q.pop_front();
      confere($sformatf("%s_rd%0d", tag, a), 32'(data_out), 32'(e));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = 4'd0;

    for (int c = 0; c < 2; c++) begin
      addr = 4'($urandom_range(0, 15));
      step(1'b1, 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), "rst");
    end
    sweep("rst");

    step(0, 1, 0, 0, 0, "short_ls");
    step(0, 0, 1, 4'h3, 0, "short_w0");
    step(0, 0, 1, 4'h7, 0, "short_w1");
    step(0, 0, 1, 4'hA, 0, "short_w2");
    step(0, 0, 0, 0, 1, "short_end");
    sweep("short");

    step(0, 1, 0, 0, 0, "full_ls");
    for (int i = 0; i < 16; i++) step(0, 0, 1, 4'(i), 0, $sformatf("full_w%0d", i));
    step(0, 0, 1, 4'h5, 0, "full_w16");
    sweep("full");

    step(0, 1, 0, 0, 0, "sim_ls");
    step(0, 0, 1, 4'h1, 0, "sim_w0");
    step(0, 0, 1, 4'h2, 0, "sim_w1");
    step(0, 0, 1, 4'h9, 1, "sim_w2end");
    sweep("sim");

    step(0, 1, 0, 0, 0, "reload_ls");
    sweep("reload");
    step(0, 1, 1, 4'h6, 0, "restart_ls");
    step(0, 0, 0, 0, 1, "restart_end");
    sweep("restart");

    step(0, 1, 0, 0, 0, "mid_ls");
    for (int i = 0; i < 5; i++) step(0, 0, 1, 4'(i + 5), 0, $sformatf("mid_w%0d", i));
    step(1, 0, 0, 0, 0, "mid_rst");
    sweep("mid_rst");
    step(0, 1, 0, 0, 0, "after_ls");
    step(0, 0, 1, 4'h4, 0, "after_w0");
    step(0, 0, 0, 0, 1, "after_end");
    sweep("after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
